matmul_seq: RTL and testbench



---
 rtl/matmul_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_matmul_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq.sv
// matmul_seq: host-facing command sequencer for one matmul instance.
// It decodes LOAD_VEC / MATMUL commands from the host byte stream and
// writes the vector SRAM. It frames the matmul input stream, and returns
// each 32-bit row result LSB first through a single-word TX buffer.
module matmul_seq #(
    parameter int MAX_DIM         = 16,
    parameter int SRAM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 host_rx_data,
    input  logic                       host_rx_valid,
    output logic                       host_rx_ready,
    output logic [7:0]                 host_tx_data,
    output logic                       host_tx_valid,
    input  logic                       host_tx_ready,
    output logic [7:0]                 mm_in_data,
    output logic                       mm_in_valid,
    input  logic                       mm_in_ready,
    input  logic [31:0]                mm_out_data,
    input  logic                       mm_out_valid,
    output logic                       mm_out_ready,
    input  logic                       mm_sram_we,
    input  logic [SRAM_ADDR_WIDTH-1:0] mm_sram_addr,
    output logic                       sram_we,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [7:0]                 sram_din,
    output logic                       busy,
    output logic                       err
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_VLEN    = 4'd1;
    localparam logic [3:0] S_VDATA   = 4'd2;
    localparam logic [3:0] S_MDIM_V  = 4'd3;
    localparam logic [3:0] S_MDIM_H  = 4'd4;
    localparam logic [3:0] S_MHDR_V  = 4'd5;
    localparam logic [3:0] S_MHDR_H  = 4'd6;
    localparam logic [3:0] S_MSTREAM = 4'd7;
    localparam logic [3:0] S_DRAIN   = 4'd8;
    localparam logic [3:0] S_ACK     = 4'd9;

    localparam logic [7:0] OP_LOAD_VEC = 8'h01;
    localparam logic [7:0] OP_MATMUL   = 8'h02;
    localparam logic [7:0] CODE_ERR    = 8'hEE;
    localparam logic [7:0] CODE_VEC    = 8'hA1;
    localparam logic [7:0] CODE_MM     = 8'hA2;

    // A dimension/length of zero or above MAX_DIM is rejected.
    function automatic logic dim_bad(input logic [7:0] d);
        return (d == 8'd0) || (int'(d) > MAX_DIM);
    endfunction

    logic [3:0]  state_q, state_d;
    logic        init_q;
    logic        err_q, err_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  vdim_q, vdim_d;
    logic [7:0]  hdim_q, hdim_d;
    logic [15:0] bytes_left_q, bytes_left_d;
    logic [7:0]  rows_out_q, rows_out_d;
    logic [7:0]  code_q, code_d;
    logic [31:0] tx_word_q, tx_word_d;
    logic [1:0]  tx_cnt_q, tx_cnt_d;
    logic        tx_full_q, tx_full_d;

    logic rx_fire;
    logic tx_fire;
    logic word_fire;
    logic code_load;

    assign host_tx_valid = tx_full_q;
    assign host_tx_data  = tx_word_q[7:0];
    // init_q keeps the host and result handshakes closed for the cycle right after reset.
    assign mm_out_ready  = init_q && !tx_full_q;
    assign busy          = (state_q != S_IDLE) || tx_full_q;
    assign err           = err_q;

    // Per-state handshake steering and the vector-SRAM port mux.
    always_comb begin
        host_rx_ready = 1'b0;
        mm_in_data    = 8'h00;
        mm_in_valid   = 1'b0;
        sram_we       = mm_sram_we;
        sram_addr     = mm_sram_addr;
        sram_din      = 8'h00;
        case (state_q)
            S_IDLE:                      host_rx_ready = init_q;
            S_VLEN, S_MDIM_V, S_MDIM_H:  host_rx_ready = 1'b1;
            S_VDATA: begin
                host_rx_ready = 1'b1;
                sram_we       = host_rx_valid;
                sram_addr     = SRAM_ADDR_WIDTH'(idx_q);
                sram_din      = host_rx_data;
            end
            S_MHDR_V: begin
                mm_in_valid = 1'b1;
                mm_in_data  = vdim_q;
            end
            S_MHDR_H: begin
                mm_in_valid = 1'b1;
                mm_in_data  = hdim_q;
            end
            S_MSTREAM: begin
                mm_in_data    = host_rx_data;
                mm_in_valid   = host_rx_valid;
                host_rx_ready = mm_in_ready;
            end
            default: ;
        endcase
    end

    // Command FSM, TX buffer and counters: next-state computation.
    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        len_d        = len_q;
        idx_d        = idx_q;
        vdim_d       = vdim_q;
        hdim_d       = hdim_q;
        bytes_left_d = bytes_left_q;
        rows_out_d   = rows_out_q;
        code_d       = code_q;
        tx_word_d    = tx_word_q;
        tx_cnt_d     = tx_cnt_q;
        tx_full_d    = tx_full_q;

        rx_fire   = host_rx_valid && host_rx_ready;
        tx_fire   = tx_full_q && host_tx_ready;
        word_fire = mm_out_valid && mm_out_ready;
        // A result word waiting on the matmul side wins over a pending code.
        code_load = (state_q == S_ACK) && !tx_full_q && !mm_out_valid;

        case (state_q)
            S_IDLE: if (rx_fire) begin
                if (host_rx_data == OP_LOAD_VEC)     state_d = S_VLEN;
                else if (host_rx_data == OP_MATMUL)  state_d = S_MDIM_V;
                else begin
                    code_d  = CODE_ERR;
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_VLEN: if (rx_fire) begin
                len_d = host_rx_data;
                if (dim_bad(host_rx_data)) begin
                    code_d  = CODE_ERR;
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    idx_d   = 8'd0;
                    state_d = S_VDATA;
                end
            end
            S_VDATA: if (rx_fire) begin
                idx_d = idx_q + 8'd1;
                if (idx_q == len_q - 8'd1) begin
                    code_d  = CODE_VEC;
                    state_d = S_ACK;
                end
            end
            S_MDIM_V: if (rx_fire) begin
                vdim_d  = host_rx_data;
                state_d = S_MDIM_H;
            end
            S_MDIM_H: if (rx_fire) begin
                hdim_d = host_rx_data;
                if (dim_bad(vdim_q) || dim_bad(host_rx_data)) begin
                    code_d  = CODE_ERR;
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    state_d = S_MHDR_V;
                end
            end
            S_MHDR_V: if (mm_in_ready) state_d = S_MHDR_H;
            S_MHDR_H: if (mm_in_ready) begin
                bytes_left_d = 16'(vdim_q) * 16'(hdim_q);
                rows_out_d   = 8'd0;
                state_d      = S_MSTREAM;
            end
            S_MSTREAM: if (rx_fire) begin
                bytes_left_d = bytes_left_q - 16'd1;
                if (bytes_left_q == 16'd1) state_d = S_DRAIN;
            end
            S_DRAIN: if ((rows_out_q == vdim_q) && !tx_full_q) begin
                code_d  = CODE_MM;
                state_d = S_ACK;
            end
            S_ACK: if (code_load) begin
                tx_word_d = {24'h000000, code_q};
                tx_cnt_d  = 2'd0;
                tx_full_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (tx_fire) begin
            if (tx_cnt_q == 2'd0) begin
                tx_full_d = 1'b0;
            end else begin
                tx_word_d = {8'h00, tx_word_q[31:8]};
                tx_cnt_d  = tx_cnt_q - 2'd1;
            end
        end

        if (word_fire) begin
            tx_word_d  = mm_out_data;
            tx_cnt_d   = 2'd3;
            tx_full_d  = 1'b1;
            rows_out_d = rows_out_d + 8'd1;
        end
    end

    // Control state and counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            init_q       <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= 8'd0;
            bytes_left_q <= 16'd0;
            rows_out_q   <= 8'd0;
            tx_cnt_q     <= 2'd0;
            tx_full_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_q       <= 1'b1;
            err_q        <= err_d;
            idx_q        <= idx_d;
            bytes_left_q <= bytes_left_d;
            rows_out_q   <= rows_out_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_full_q    <= tx_full_d;
        end
    end

    // Data-only registers; their contents are qualified by the control state.
    always_ff @(posedge clk) begin
        len_q     <= len_d;
        vdim_q    <= vdim_d;
        hdim_q    <= hdim_d;
        code_q    <= code_d;
        tx_word_q <= tx_word_d;
    end

endmodule

// File: tb/tb_matmul_seq.sv
// Testbench for matmul_seq: directed host commands against a small
// behavioural matmul model and a vector-SRAM model on the bench side.
`timescale 1ns/1ps
module tb_matmul_seq;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    host_rx_data;
    logic          host_rx_valid;
    logic          host_rx_ready;
    logic [7:0]    host_tx_data;
    logic          host_tx_valid;
    logic          host_tx_ready;
    logic [7:0]    mm_in_data;
    logic          mm_in_valid;
    logic          mm_in_ready;
    logic [31:0]   mm_out_data;
    logic          mm_out_valid;
    logic          mm_out_ready;
    logic          mm_sram_we;
    logic [AW-1:0] mm_sram_addr;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_din;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    matmul_seq #(.MAX_DIM(16), .SRAM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
        .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
        .mm_in_data(mm_in_data), .mm_in_valid(mm_in_valid), .mm_in_ready(mm_in_ready),
        .mm_out_data(mm_out_data), .mm_out_valid(mm_out_valid), .mm_out_ready(mm_out_ready),
        .mm_sram_we(mm_sram_we), .mm_sram_addr(mm_sram_addr),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din),
        .busy(busy), .err(err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // ---------------- behavioural matmul + SRAM model ----------------
    logic [7:0]  vmem [0:1023];
    logic [31:0] res_mem [0:63];
    int unsigned res_wr, res_rd;
    int          m_st, m_col, m_row;
    logic [7:0]  m_v, m_h;
    logic [31:0] m_acc, m_acc_nxt;

    assign m_acc_nxt    = m_acc + 32'(mm_in_data) * 32'(vmem[m_col]);
    assign mm_out_valid = (res_wr != res_rd);
    assign mm_out_data  = res_mem[res_rd % 64];

    always @(negedge clk) begin
        if (rst) begin
            m_st <= 0; m_col <= 0; m_row <= 0; m_acc <= 32'd0;
            res_wr <= 0; res_rd <= 0;
        end else begin
            if (sram_we) vmem[sram_addr] <= sram_din;
            if (mm_out_valid && mm_out_ready) res_rd <= res_rd + 1;
            if (mm_in_valid && mm_in_ready) begin
                if (m_st == 0) begin
                    m_v <= mm_in_data; m_st <= 1;
                end else if (m_st == 1) begin
                    m_h <= mm_in_data; m_st <= 2;
                    m_col <= 0; m_row <= 0; m_acc <= 32'd0;
                end else if (m_col == int'(m_h) - 1) begin
                    res_mem[res_wr % 64] <= m_acc_nxt;
                    res_wr <= res_wr + 1;
                    m_acc  <= 32'd0;
                    m_col  <= 0;
                    if (m_row == int'(m_v) - 1) m_st <= 0;
                    else m_row <= m_row + 1;
                end else begin
                    m_acc <= m_acc_nxt;
                    m_col <= m_col + 1;
                end
            end
        end
    end

    // ---------------- monitors (mid-cycle sampling) ----------------
    logic [7:0]    tx_q [$];
    logic [7:0]    mi_q [$];
    logic [AW+7:0] sw_q [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (host_tx_valid && host_tx_ready) tx_q.push_back(host_tx_data);
            if (mm_in_valid && mm_in_ready)     mi_q.push_back(mm_in_data);
            if (sram_we)                        sw_q.push_back({sram_addr, sram_din});
        end
    end

    // ---------------- ready drivers ----------------
    logic bp_mode = 1'b0;

    initial begin
        int cyc = 0;
        host_tx_ready = 1'b1;
        mm_in_ready   = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            host_tx_ready = bp_mode ? ((cyc % 4) == 0) : 1'b1;
            mm_in_ready   = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // ---------------- host-side tasks ----------------
    logic [7:0] cmd_q [$];
    logic [7:0] exp_q [$];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  guard = 0;
        bit  done  = 0;
        if (bp_mode) repeat ($urandom_range(0, 2)) tick();
        host_rx_valid = 1'b1;
        host_rx_data  = b;
        while (!done) begin
            @(negedge clk);
            done = host_rx_ready;
            tick();
            guard++;
            if (!done && guard > 2000) begin
                check("rx_accept_timeout", 32'(guard), 32'd0);
                done = 1;
            end
        end
        host_rx_valid = 1'b0;
    endtask

    task automatic send_cmd();
        for (int i = 0; i < cmd_q.size(); i++) send_byte(cmd_q[i]);
        cmd_q.delete();
    endtask

    task automatic check_tx(input string tag);
        int g = 0;
        while (tx_q.size() < exp_q.size() && g < 20000) begin
            tick();
            g++;
        end
        repeat (10) tick();
        check({tag, "_len"}, 32'(tx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i),
                  (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hFFFF_FFFF, {24'h0, exp_q[i]});
        tx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outs(input string tag);
        @(negedge clk);
        check(tag, 32'({host_rx_ready, host_tx_valid, mm_in_valid, mm_out_ready, sram_we, busy, err}), 32'd0);
        tick();
    endtask

    task automatic run_load_vec();
        cmd_q = '{8'h01, 8'h03, 8'h05, 8'h06, 8'h07};
        send_cmd();
        exp_q = '{8'hA1};
        check_tx("load_vec");
    endtask

    task automatic run_matmul_2x3(input string tag);
        mi_q.delete();
        cmd_q = '{8'h02, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_cmd();
        exp_q = '{8'h26, 8'h00, 8'h00, 8'h00, 8'h5C, 8'h00, 8'h00, 8'h00, 8'hA2};
        check_tx(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed test sequence ----------------
    initial begin
        logic [7:0] mi_exp [8];
        mi_exp = '{8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        rst = 1'b1; host_rx_valid = 1'b0; host_rx_data = 8'h00;
        mm_sram_we = 1'b0; mm_sram_addr = '0;
        repeat (3) tick();
        check_reset_outs("reset_outputs");
        rst = 1'b0;
        repeat (2) tick();

        // Test 1: vector load
        sw_q.delete();
        cmd_q = '{8'h01, 8'h03, 8'h05, 8'h06, 8'h07};
        send_cmd();
        @(negedge clk);
        check("busy_after_cmd", 32'(busy), 32'd1);
        tick();
        exp_q = '{8'hA1};
        check_tx("vec_ack");
        @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
        check("sram_wr_count", 32'(sw_q.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("sram_wr%0d", i), (i < sw_q.size()) ? 32'(sw_q[i]) : 32'hFFFF_FFFF,
                  32'({10'(i), 8'(5 + i)}));
        tick();

        // SRAM mux passthrough outside VDATA
        mm_sram_we = 1'b1; mm_sram_addr = 10'h155;
        @(negedge clk);
        check("sram_passthru", 32'({sram_we, sram_addr, sram_din}), 32'({1'b1, 10'h155, 8'h00}));
        tick();
        mm_sram_we = 1'b0; mm_sram_addr = '0;
        tick();
        sw_q.delete();

        // Test 2: 2x3 multiply
        run_matmul_2x3("mm2x3");
        check("mm_in_count", 32'(mi_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("mm_in%0d", i), (i < mi_q.size()) ? {24'h0, mi_q[i]} : 32'hFFFF_FFFF,
                  {24'h0, mi_exp[i]});

        // Test 3: same multiply under back-pressure
        bp_mode = 1'b1;
        run_matmul_2x3("mm2x3_bp");
        bp_mode = 1'b0;
        repeat (2) tick();

        // Test 4: errors
        cmd_q = '{8'h07};
        send_cmd();
        exp_q = '{8'hEE};
        check_tx("bad_opcode");
        @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        tick();
        cmd_q = '{8'h02, 8'h00, 8'h04};
        send_cmd();
        exp_q = '{8'hEE};
        check_tx("zero_vdim");
        cmd_q = '{8'h01, 8'h01, 8'h09};
        send_cmd();
        exp_q = '{8'hA1};
        check_tx("after_err_load");
        cmd_q = '{8'h01, 8'h11};
        send_cmd();
        exp_q = '{8'hEE};
        check_tx("len_too_big");
        @(negedge clk);
        check("err_still_set", 32'(err), 32'd1);
        tick();

        // Test 5: reset in the middle of MSTREAM
        run_load_vec();
        cmd_q = '{8'h02, 8'h02, 8'h03, 8'h01, 8'h02};
        send_cmd();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outs("mid_reset_outputs");
        repeat (30) tick();
        check("mid_reset_no_tx", 32'(tx_q.size()), 32'd0);
        tx_q.delete();
        run_load_vec();
        run_matmul_2x3("mm2x3_after_rst");

        // Test 6: maximum size, all 0xFF
        cmd_q = '{8'h01, 8'h10};
        for (int i = 0; i < 16; i++) cmd_q.push_back(8'hFF);
        send_cmd();
        exp_q = '{8'hA1};
        check_tx("max_vec");
        cmd_q = '{8'h02, 8'h10, 8'h10};
        for (int i = 0; i < 256; i++) cmd_q.push_back(8'hFF);
        send_cmd();
        // 16 * 255 * 255 = 1040400 = 0x000FE010, sent LSB first
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h10);
            exp_q.push_back(8'hE0);
            exp_q.push_back(8'h0F);
            exp_q.push_back(8'h00);
        end
        exp_q.push_back(8'hA2);
        check_tx("max_mm");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
